// File: rtl/mem_bus_responder_pkg.sv
// Shared encodings for the memory bus responder: CPU op codes, FSM states
// and the line offset width.
package mem_bus_responder_pkg;

  localparam logic [1:0] OP_IDLE       = 2'b00;
  localparam logic [1:0] OP_READ       = 2'b01;
  localparam int         LINE_OFFSET_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_COLLECT,
    ST_DELIVER,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_bus_responder_line_assembler.sv
// Beat-to-line assembler: inserts host read beats into a line register,
// lowest-addressed beat first, and flags the beat that completes the line.
module line_assembler #(
  parameter int INW   = 512,
  parameter int BEATW = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             beat_valid,
  input  logic [BEATW-1:0] beat_data,
  output logic [INW-1:0]   line_next,
  output logic             last_beat
);

  localparam int BEATS = INW / BEATW;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [INW-1:0]   line_q, line_d, line_base;

  // clear restarts from beat 0 in the same cycle, so a beat arriving
  // together with the start of collection lands in slot 0.
  always_comb begin
    cnt_base  = clear ? '0 : cnt_q;
    line_base = clear ? '0 : line_q;
    cnt_d     = cnt_base;
    line_d    = line_base;
    last_beat = 1'b0;
    if (beat_valid) begin
      line_d[cnt_base*BEATW +: BEATW] = beat_data;
      last_beat = (cnt_base == CNT_W'(BEATS - 1));
      cnt_d     = last_beat ? '0 : cnt_base + CNT_W'(1);
    end
  end

  assign line_next = line_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// CPU line-read responder: fetches a line from the host in beats and delivers
// it on the common data bus. Optional last-line cache: RESP_LINE_CACHE_EN.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDRW = 32,
  parameter int INW   = 512,
  parameter int BEATW = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [ADDRW-1:0] mem_address,
  input  logic             ifetch,
  output logic             host_req,
  output logic [ADDRW-1:0] host_addr,
  input  logic             host_ack,
  input  logic             host_rvalid,
  input  logic [BEATW-1:0] host_rdata,
  output logic [INW-1:0]   common_data_bus_in,
  output logic             instr_write_en,
  output logic             mem_write_en,
  output logic             busy
);

  localparam int LAW = ADDRW - LINE_OFFSET_W;

  state_t           state_q, state_d;
  logic [LAW-1:0]   line_addr_q, line_addr_d;
  logic             ifetch_q, ifetch_d;
  logic [INW-1:0]   bus_q, bus_d;

  logic [LAW-1:0]   req_line;
  logic             rd_req;
  logic             cache_hit;
  logic             asm_clear, asm_valid, asm_last;
  logic [INW-1:0]   asm_line;
  logic [LINE_OFFSET_W-1:0] unused_offset;

  assign req_line      = mem_address[ADDRW-1:LINE_OFFSET_W];
  assign unused_offset = mem_address[LINE_OFFSET_W-1:0];
  assign rd_req        = (op == OP_READ);

`ifdef RESP_LINE_CACHE_EN
  // The bus register already holds the last delivered line, so it doubles as
  // the cached data; line_addr_q is its tag while cache_valid_q is set.
  logic cache_valid_q, cache_valid_d;

  assign cache_hit = cache_valid_q && (req_line == line_addr_q);

  always_comb begin
    cache_valid_d = cache_valid_q;
    if (state_q == ST_IDLE && rd_req && !cache_hit) cache_valid_d = 1'b0;
    if (state_q == ST_DELIVER)                      cache_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cache_valid_q <= 1'b0;
    else     cache_valid_q <= cache_valid_d;
  end
`else
  assign cache_hit = 1'b0;
`endif

  line_assembler #(.INW(INW), .BEATW(BEATW)) u_line_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .beat_valid (asm_valid),
    .beat_data  (host_rdata),
    .line_next  (asm_line),
    .last_beat  (asm_last)
  );

  always_comb begin
    state_d        = state_q;
    line_addr_d    = line_addr_q;
    ifetch_d       = ifetch_q;
    bus_d          = bus_q;
    asm_clear      = 1'b0;
    asm_valid      = 1'b0;
    host_req       = 1'b0;
    instr_write_en = 1'b0;
    mem_write_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          ifetch_d = ifetch;
          if (cache_hit) begin
            state_d = ST_DELIVER;
          end else begin
            line_addr_d = req_line;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        host_req = 1'b1;
        if (host_ack) begin
          asm_clear = 1'b1;
          asm_valid = host_rvalid;
          if (asm_last) begin
            bus_d   = asm_line;
            state_d = ST_DELIVER;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        asm_valid = host_rvalid;
        if (asm_last) begin
          bus_d   = asm_line;
          state_d = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        instr_write_en = ifetch_q;
        mem_write_en   = !ifetch_q;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        // Wait for the request to drop or move so it is not served twice.
        if (!rd_req || req_line != line_addr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      line_addr_q <= '0;
      ifetch_q    <= 1'b0;
      bus_q       <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      ifetch_q    <= ifetch_d;
      bus_q       <= bus_d;
    end
  end

  assign host_addr          = {line_addr_q, {LINE_OFFSET_W{1'b0}}};
  assign common_data_bus_in = bus_q;
  assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed testbench for mem_bus_responder; also exercises the cached path
// when built with RESP_LINE_CACHE_EN.
module tb_mem_bus_responder;

  localparam int ADDRW = 32;
  localparam int INW   = 512;
  localparam int BEATW = 64;

  logic             clk;
  logic             rst;
  logic [1:0]       op;
  logic [ADDRW-1:0] mem_address;
  logic             ifetch;
  logic             host_req;
  logic [ADDRW-1:0] host_addr;
  logic             host_ack;
  logic             host_rvalid;
  logic [BEATW-1:0] host_rdata;
  logic [INW-1:0]   common_data_bus_in;
  logic             instr_write_en;
  logic             mem_write_en;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_responder #(.ADDRW(ADDRW), .INW(INW), .BEATW(BEATW)) dut (
    .clk                (clk),
    .rst                (rst),
    .op                 (op),
    .mem_address        (mem_address),
    .ifetch             (ifetch),
    .host_req           (host_req),
    .host_addr          (host_addr),
    .host_ack           (host_ack),
    .host_rvalid        (host_rvalid),
    .host_rdata         (host_rdata),
    .common_data_bus_in (common_data_bus_in),
    .instr_write_en     (instr_write_en),
    .mem_write_en       (mem_write_en),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [INW-1:0] got, input logic [INW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full read: sample, REQ (immediate ack), beats base+0..base+7, DELIVER
  // checks, then one step into DONE.
  task automatic do_read(input logic [31:0] addr, input logic ifet, input int stall,
                         input logic [63:0] base, input logic ack_beat,
                         input logic move_addr, input logic hold_op);
    logic [INW-1:0] exp;
    logic [31:0]    aligned;
    int             steps;
    int             first;
    exp = '0;
    for (int i = 0; i < 8; i++) exp[i*64 +: 64] = base + 64'(i);
    aligned = {addr[31:6], 6'b0};
    op = 2'b01; mem_address = addr; ifetch = ifet;
    step(); steps = 1;
    check("req_host_req", host_req, 1'b1);
    check("req_host_addr", host_addr, aligned);
    ifetch   = ~ifet;
    host_ack = 1'b1;
    first    = 0;
    if (ack_beat) begin
      host_rvalid = 1'b1; host_rdata = base; first = 1;
    end
    step(); steps++;
    host_ack = 1'b0; host_rvalid = 1'b0;
    for (int i = first; i < 8; i++) begin
      for (int s = 0; s < stall; s++) begin
        host_rvalid = 1'b0;
        step(); steps++;
      end
      host_rvalid = 1'b1; host_rdata = base + 64'(i);
      if (move_addr && i == 4) mem_address = addr + 32'h400;
      step(); steps++;
    end
    host_rvalid = 1'b0;
    check("dlv_instr_we", instr_write_en, ifet);
    check("dlv_mem_we", mem_write_en, !ifet);
    check("dlv_bus", common_data_bus_in, exp);
    check("dlv_host_addr", host_addr, aligned);
    if (stall == 0) check("dlv_latency", steps, ack_beat ? 9 : 10);
    if (!hold_op) op = 2'b00;
    step();
    check("done_strobes", {instr_write_en, mem_write_en}, 2'b00);
    check("done_bus", common_data_bus_in, exp);
    $display("read addr=%08h ifetch=%0d stall=%0d ack_beat=%0d delivered", addr, ifet, stall, ack_beat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [INW-1:0] line1;
    int             extra;
    line1 = 512'h0000000000000008_0000000000000007_0000000000000006_0000000000000005_0000000000000004_0000000000000003_0000000000000002_0000000000000001;
    rst = 1'b1; op = 2'b00; mem_address = '0; ifetch = 1'b0;
    host_ack = 1'b0; host_rvalid = 1'b0; host_rdata = '0;
    step(); step(); step();
    check("rst_host_req", host_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {instr_write_en, mem_write_en}, 2'b00);
    check("rst_bus", common_data_bus_in, '0);
    check("rst_host_addr", host_addr, '0);
    rst = 1'b0;
    step();

    // Data read of 0x140, beats 1..8
    do_read(32'h0000_0140, 1'b0, 0, 64'h1, 1'b0, 1'b0, 1'b0);
    check("line1_literal", common_data_bus_in, line1);
    step();
    check("t1_idle", busy, 1'b0);

    // Instruction fetch from an unaligned address
    do_read(32'h0000_007F, 1'b1, 0, 64'hA0, 1'b0, 1'b0, 1'b0);
    step();
    check("t2_idle", busy, 1'b0);

    // Request held after delivery must not be served twice
    do_read(32'h0000_0200, 1'b0, 0, 64'h300, 1'b0, 1'b0, 1'b1);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_write_en || mem_write_en || host_req) extra++;
      step();
    end
    check("hold_no_strobe", extra, 0);
    check("hold_busy", busy, 1'b1);
    op = 2'b00;
    step();
    check("hold_release_idle", busy, 1'b0);
    do_read(32'h0000_0240, 1'b0, 0, 64'h400, 1'b0, 1'b0, 1'b0);
    step();

    // First beat arrives together with host_ack
    do_read(32'h0000_0580, 1'b0, 0, 64'h500, 1'b1, 1'b0, 1'b0);
    step();

    // Stalled beats and an address change mid-collection
    do_read(32'h0000_0600, 1'b1, 3, 64'h700, 1'b0, 1'b1, 1'b0);
    step();
    check("t5_idle", busy, 1'b0);

    // Reset after beat 3 aborts the transfer
    op = 2'b01; mem_address = 32'h0000_0800; ifetch = 1'b0;
    step();
    host_ack = 1'b1;
    step();
    host_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_rvalid = 1'b1; host_rdata = 64'h900 + 64'(i);
      step();
    end
    op = 2'b00; rst = 1'b1; host_rdata = 64'h904;
    step();
    check("abort_host_req", host_req, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_strobes", {instr_write_en, mem_write_en}, 2'b00);
    check("abort_bus", common_data_bus_in, '0);
    check("abort_host_addr", host_addr, '0);
    rst = 1'b0;
    for (int i = 5; i < 8; i++) begin
      host_rdata = 64'h900 + 64'(i);
      step();
    end
    host_rvalid = 1'b0;
    check("stray_busy", busy, 1'b0);
    check("stray_bus", common_data_bus_in, '0);
    $display("read addr=00000800 aborted by reset after beat 3");
    do_read(32'h0000_0800, 1'b0, 0, 64'hA00, 1'b0, 1'b0, 1'b0);
    step();

`ifdef RESP_LINE_CACHE_EN
    begin
      logic [INW-1:0] exp_c;
      exp_c = '0;
      for (int i = 0; i < 8; i++) exp_c[i*64 +: 64] = 64'hB00 + 64'(i);
      do_read(32'h0000_01C0, 1'b0, 0, 64'hB00, 1'b0, 1'b0, 1'b0);
      step();
      op = 2'b01; mem_address = 32'h0000_01C0; ifetch = 1'b0;
      step();
      check("hit_mem_we", mem_write_en, 1'b1);
      check("hit_instr_we", instr_write_en, 1'b0);
      check("hit_no_host_req", host_req, 1'b0);
      check("hit_bus", common_data_bus_in, exp_c);
      op = 2'b00;
      step();
      step();
      check("hit_idle", busy, 1'b0);
      $display("read addr=000001c0 served from line cache");
    end
`else
    do_read(32'h0000_01C0, 1'b0, 0, 64'hB00, 1'b0, 1'b0, 1'b0);
    step();
    do_read(32'h0000_01C0, 1'b0, 0, 64'hC00, 1'b0, 1'b0, 1'b0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
